// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port data memory between port A (CPU) and port B (loader),
// sequencing each access through IDLE/ISSUE/RDWAIT and returning read data with a one-cycle pulse.
module data_mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_e;
    state_e              state_q;
    logic                win_b_q;
    logic                last_b_q;
    logic                pick_b_d;
    logic                a_gnt_q;
    logic                b_gnt_q;
    logic                a_rvalid_q;
    logic                b_rvalid_q;
    logic [DATA_W-1:0]   a_rdata_q;
    logic [DATA_W-1:0]   b_rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic                busy_q;
    // On a tie, round-robin hands the bus to whichever port did not win last time
    assign pick_b_d = b_req && (!a_req || (PRIO_MODE == 0 && !last_b_q));
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_b_q     <= 1'b0;
            last_b_q    <= 1'b1;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= a_req || b_req;
                    if (a_req || b_req) begin
                        state_q     <= ISSUE;
                        win_b_q     <= pick_b_d;
                        last_b_q    <= pick_b_d;
                        mem_addr_q  <= pick_b_d ? b_addr : a_addr;
                        mem_wdata_q <= pick_b_d ? b_wdata : a_wdata;
                        mem_write_q <= pick_b_d ? b_we : a_we;
                        mem_read_q  <= pick_b_d ? !b_we : !a_we;
                        a_gnt_q     <= !pick_b_d;
                        b_gnt_q     <= pick_b_d;
                    end
                end
                ISSUE: begin
                    state_q <= mem_write_q ? IDLE : RDWAIT;
                    busy_q  <= !mem_write_q;
                end
                RDWAIT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b1;
                    if (win_b_q) begin
                        b_rdata_q  <= mem_rdata;
                        b_rvalid_q <= 1'b1;
                    end else begin
                        a_rdata_q  <= mem_rdata;
                        a_rvalid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
    assign a_gnt     = a_gnt_q;
    assign b_gnt     = b_gnt_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: two arbiters (round-robin and fixed priority), each with its own memory,
// checked every cycle against a transaction-scheduling model plus directed literal expectations.
module tb_data_mem_arbiter;
    typedef struct packed {logic we; logic [7:0] addr; logic [7:0] wdata;} cmd_t;

    logic       clk = 1'b0;
    logic       rst [2];
    logic       a_req [2], a_we [2], a_gnt [2], a_rvalid [2];
    logic       b_req [2], b_we [2], b_gnt [2], b_rvalid [2];
    logic [7:0] a_addr [2], a_wdata [2], a_rdata [2];
    logic [7:0] b_addr [2], b_wdata [2], b_rdata [2];
    logic [7:0] mem_addr [2], mem_wdata [2], mem_rdata [2];
    logic       mem_read [2], mem_write [2], busy [2];

    int   checks = 0, failures = 0, cyc = 0;
    cmd_t cq [4][$];
    cmd_t cur [4];
    bit   act [4];
    bit   gap_en = 1'b0;
    int   rst_cnt [2] = '{3, 3};
    // model state: pending bus/return events in a small ring indexed by cycle
    bit         ev_gv [2][8];
    int         ev_gp [2][8];
    cmd_t       ev_gc [2][8];
    bit         ev_rv [2][8];
    int         ev_rp [2][8];
    logic [7:0] ev_rd [2][8];
    logic [7:0] h_addr [2], h_wdata [2];
    logic [7:0] h_rd [2][2];
    bit         last_b [2], live [2];
    int         busy_end [2], next_arb [2];
    logic [7:0] shadow [2][256];
    logic [7:0] mem [2][256];
    int         gnt_log [2][$];
    int         rd_log [2][$];

    for (genvar i = 0; i < 2; i++) begin : g_dut
        data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_MODE(i)) u_dut (
            .clk(clk), .rst(rst[i]),
            .a_req(a_req[i]), .a_we(a_we[i]), .a_addr(a_addr[i]), .a_wdata(a_wdata[i]),
            .a_gnt(a_gnt[i]), .a_rvalid(a_rvalid[i]), .a_rdata(a_rdata[i]),
            .b_req(b_req[i]), .b_we(b_we[i]), .b_addr(b_addr[i]), .b_wdata(b_wdata[i]),
            .b_gnt(b_gnt[i]), .b_rvalid(b_rvalid[i]), .b_rdata(b_rdata[i]),
            .mem_addr(mem_addr[i]), .mem_read(mem_read[i]), .mem_write(mem_write[i]),
            .mem_wdata(mem_wdata[i]), .mem_rdata(mem_rdata[i]), .busy(busy[i])
        );
    end

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] init_val(int g, int a);
        if (a == 0) return 8'd75;
        if (a == 1) return 8'h07;
        if (a == 2) return 8'h5E;
        return 8'(a * 37 + 13 + g * 91);
    endfunction

    function automatic cmd_t mk(logic we, logic [7:0] addr, logic [7:0] wdata);
        cmd_t c;
        c.we = we;
        c.addr = addr;
        c.wdata = wdata;
        return c;
    endfunction

    task automatic chk(string name, int g, logic [31:0] act_v, logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s inst%0d cyc=%0d actual=%0h required=%0h", name, g, cyc, act_v, exp_v);
        end
    endtask

    // single-port memory seen by each arbiter: registered read, write on memWrite
    initial begin
        for (int g = 0; g < 2; g++)
            for (int a = 0; a < 256; a++) mem[g][a] = init_val(g, a);
        forever begin
            @(posedge clk);
            for (int g = 0; g < 2; g++) begin
                mem_rdata[g] <= mem_read[g] ? mem[g][mem_addr[g]] : 8'($urandom);
                if (mem_write[g]) mem[g][mem_addr[g]] = mem_wdata[g];
            end
        end
    end

    // per-cycle: check outputs, run requesters, apply reset, schedule the next arbitration
    initial begin
        for (int g = 0; g < 2; g++)
            for (int a = 0; a < 256; a++) shadow[g][a] = init_val(g, a);
        forever begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < 2; g++) begin
                int s, p, k;
                logic [1:0] eg, erv;
                logic er, ew;
                bit r, pb;
                cmd_t c;
                s = cyc % 8;
                eg = '0;
                erv = '0;
                er = 1'b0;
                ew = 1'b0;
                if (ev_gv[g][s]) begin
                    p = ev_gp[g][s];
                    c = ev_gc[g][s];
                    ev_gv[g][s] = 1'b0;
                    eg[p] = 1'b1;
                    h_addr[g] = c.addr;
                    h_wdata[g] = c.wdata;
                    ew = c.we;
                    er = !c.we;
                    if (c.we) shadow[g][c.addr] = c.wdata;
                    else begin
                        ev_rv[g][(cyc + 2) % 8] = 1'b1;
                        ev_rp[g][(cyc + 2) % 8] = p;
                        ev_rd[g][(cyc + 2) % 8] = shadow[g][c.addr];
                    end
                end
                if (ev_rv[g][s]) begin
                    p = ev_rp[g][s];
                    ev_rv[g][s] = 1'b0;
                    erv[p] = 1'b1;
                    h_rd[g][p] = ev_rd[g][s];
                end
                if (live[g]) begin
                    chk("a_gnt", g, 32'(a_gnt[g]), 32'(eg[0]));
                    chk("b_gnt", g, 32'(b_gnt[g]), 32'(eg[1]));
                    chk("a_rvalid", g, 32'(a_rvalid[g]), 32'(erv[0]));
                    chk("b_rvalid", g, 32'(b_rvalid[g]), 32'(erv[1]));
                    chk("a_rdata", g, 32'(a_rdata[g]), 32'(h_rd[g][0]));
                    chk("b_rdata", g, 32'(b_rdata[g]), 32'(h_rd[g][1]));
                    chk("mem_addr", g, 32'(mem_addr[g]), 32'(h_addr[g]));
                    chk("mem_wdata", g, 32'(mem_wdata[g]), 32'(h_wdata[g]));
                    chk("mem_read", g, 32'(mem_read[g]), 32'(er));
                    chk("mem_write", g, 32'(mem_write[g]), 32'(ew));
                    chk("busy", g, 32'(busy[g]), 32'(cyc <= busy_end[g]));
                    chk("rd_wr_excl", g, 32'(mem_read[g] & mem_write[g]), 32'd0);
                end
                if (a_gnt[g] === 1'b1) gnt_log[g].push_back(0);
                if (b_gnt[g] === 1'b1) gnt_log[g].push_back(1);
                if (a_rvalid[g] === 1'b1) rd_log[g].push_back(int'(a_rdata[g]));
                if (b_rvalid[g] === 1'b1) rd_log[g].push_back(256 + int'(b_rdata[g]));
                for (int j = 0; j < 2; j++) begin
                    k = g * 2 + j;
                    if (eg[j]) act[k] = 1'b0;
                    if (!act[k] && cq[k].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
                        cur[k] = cq[k].pop_front();
                        act[k] = 1'b1;
                    end
                end
                a_req[g]   = act[g * 2];
                a_we[g]    = act[g * 2] ? cur[g * 2].we : 1'($urandom);
                a_addr[g]  = act[g * 2] ? cur[g * 2].addr : 8'($urandom);
                a_wdata[g] = act[g * 2] ? cur[g * 2].wdata : 8'($urandom);
                b_req[g]   = act[g * 2 + 1];
                b_we[g]    = act[g * 2 + 1] ? cur[g * 2 + 1].we : 1'($urandom);
                b_addr[g]  = act[g * 2 + 1] ? cur[g * 2 + 1].addr : 8'($urandom);
                b_wdata[g] = act[g * 2 + 1] ? cur[g * 2 + 1].wdata : 8'($urandom);
                r = rst_cnt[g] > 0;
                if (r) rst_cnt[g]--;
                rst[g] = r;
                if (r) begin
                    for (int j = 0; j < 8; j++) begin
                        ev_gv[g][j] = 1'b0;
                        ev_rv[g][j] = 1'b0;
                    end
                    h_addr[g] = '0;
                    h_wdata[g] = '0;
                    h_rd[g][0] = '0;
                    h_rd[g][1] = '0;
                    last_b[g] = 1'b1;
                    busy_end[g] = -1;
                    next_arb[g] = cyc + 1;
                    live[g] = 1'b1;
                end else if (live[g] && cyc >= next_arb[g] && (act[g * 2] || act[g * 2 + 1])) begin
                    pb = act[g * 2 + 1] && (!act[g * 2] || (g == 0 && !last_b[g]));
                    p = pb ? 1 : 0;
                    c = cur[g * 2 + p];
                    ev_gv[g][(cyc + 1) % 8] = 1'b1;
                    ev_gp[g][(cyc + 1) % 8] = p;
                    ev_gc[g][(cyc + 1) % 8] = c;
                    last_b[g] = pb;
                    next_arb[g] = cyc + (c.we ? 2 : 3);
                    busy_end[g] = cyc + (c.we ? 1 : 3);
                end
            end
        end
    end

    task automatic wait_quiet(int g, string name);
        int n;
        n = 0;
        while (n < 400 && !(cq[g * 2].size() == 0 && cq[g * 2 + 1].size() == 0 && !act[g * 2] &&
               !act[g * 2 + 1] && cyc > busy_end[g] + 1 && rst_cnt[g] == 0)) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL %s inst%0d timeout actual=busy required=idle", name, g);
        end
    endtask

    task automatic clear_logs();
        for (int g = 0; g < 2; g++) begin
            gnt_log[g].delete();
            rd_log[g].delete();
        end
    endtask

    task automatic do_reset(int g);
        rst_cnt[g] = 2;
        wait_quiet(g, "reset");
    endtask

    initial begin
        int exp0 [9] = '{0, 1, 0, 1, 0, 1, 0, 0, 0};
        int exp1 [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
        int n;
        repeat (6) @(posedge clk);
        wait_quiet(0, "init");
        clear_logs();
        cq[0].push_back(mk(1'b0, 8'h00, 8'h00));
        wait_quiet(0, "t1");
        chk("t1_gnts", 0, gnt_log[0].size(), 1);
        chk("t1_rd", 0, rd_log[0].size() == 1 ? rd_log[0][0] : -1, 32'h04B);

        do_reset(0);
        clear_logs();
        cq[0].push_back(mk(1'b0, 8'h01, 8'h00));
        cq[1].push_back(mk(1'b0, 8'h02, 8'h00));
        wait_quiet(0, "t2");
        chk("t2_first", 0, gnt_log[0].size() == 2 ? gnt_log[0][0] : -1, 0);
        chk("t2_second", 0, gnt_log[0].size() == 2 ? gnt_log[0][1] : -1, 1);
        chk("t2_rd_a", 0, rd_log[0].size() == 2 ? rd_log[0][0] : -1, 32'h007);
        chk("t2_rd_b", 0, rd_log[0].size() == 2 ? rd_log[0][1] : -1, 32'h15E);
        cq[0].push_back(mk(1'b0, 8'h03, 8'h00));
        wait_quiet(0, "t2b");
        clear_logs();
        cq[0].push_back(mk(1'b0, 8'h04, 8'h00));
        cq[1].push_back(mk(1'b0, 8'h05, 8'h00));
        wait_quiet(0, "t2c");
        chk("t2_tie_b", 0, gnt_log[0].size() == 2 ? gnt_log[0][0] : -1, 1);

        clear_logs();
        cq[1].push_back(mk(1'b1, 8'h10, 8'hA5));
        wait_quiet(0, "t3w");
        cq[0].push_back(mk(1'b0, 8'h10, 8'h00));
        wait_quiet(0, "t3r");
        chk("t3_rd", 0, rd_log[0].size() == 1 ? rd_log[0][0] : -1, 32'h0A5);

        do_reset(0);
        clear_logs();
        for (int g = 0; g < 2; g++) begin
            for (int j = 0; j < 6; j++) cq[g * 2].push_back(mk(1'b0, 8'($urandom), 8'h00));
            for (int j = 0; j < 3; j++) cq[g * 2 + 1].push_back(mk(1'b0, 8'($urandom), 8'h00));
        end
        wait_quiet(0, "t4_rr");
        wait_quiet(1, "t4_fixed");
        chk("t4_rr_cnt", 0, gnt_log[0].size(), 9);
        chk("t4_fx_cnt", 1, gnt_log[1].size(), 9);
        for (int j = 0; j < 9; j++) begin
            chk("t4_rr_order", 0, gnt_log[0].size() > j ? gnt_log[0][j] : -1, exp0[j]);
            chk("t4_fx_order", 1, gnt_log[1].size() > j ? gnt_log[1][j] : -1, exp1[j]);
        end

        clear_logs();
        cq[0].push_back(mk(1'b0, 8'h05, 8'h00));
        n = 0;
        while (n < 20 && gnt_log[0].size() == 0) begin
            @(posedge clk);
            n++;
        end
        chk("t5_gnt_seen", 0, gnt_log[0].size(), 1);
        rst_cnt[0] = 1;
        wait_quiet(0, "t5_rst");
        chk("t5_no_rvalid", 0, rd_log[0].size(), 0);
        cq[0].push_back(mk(1'b0, 8'h00, 8'h00));
        wait_quiet(0, "t5_after");
        chk("t5_rd", 0, rd_log[0].size() == 1 ? rd_log[0][0] : -1, 32'h04B);

        clear_logs();
        cq[1].push_back(mk(1'b1, 8'hFF, 8'h3C));
        wait_quiet(0, "t6w");
        cq[0].push_back(mk(1'b0, 8'hFF, 8'h00));
        cq[0].push_back(mk(1'b0, 8'hFE, 8'h00));
        wait_quiet(0, "t6r");
        chk("t6_rd_ff", 0, rd_log[0].size() == 2 ? rd_log[0][0] : -1, 32'h03C);
        chk("t6_rd_fe", 0, rd_log[0].size() == 2 ? rd_log[0][1] : -1, 32'(init_val(0, 254)));

        gap_en = 1'b1;
        repeat (1500) begin
            @(posedge clk);
            for (int g = 0; g < 2; g++) begin
                for (int j = 0; j < 2; j++)
                    if (cq[g * 2 + j].size() < 3 && $urandom_range(0, 2) == 0)
                        cq[g * 2 + j].push_back(mk(1'($urandom),
                            $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom_range(0, 31)), 8'($urandom)));
                if ($urandom_range(0, 149) == 0 && rst_cnt[g] == 0) rst_cnt[g] = $urandom_range(1, 2);
            end
        end
        wait_quiet(0, "rand");
        wait_quiet(1, "rand");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
